// File: rtl/div2d_stream.sv
// Streaming 2-D divergence: div = Dx(px) + Dy(py) over a raster-order frame,
// with a one-row line buffer for py and a fixed two-stage output pipeline.
module div2d_stream #(
    parameter int WIDTH     = 32,
    parameter int COLS_LOG2 = 6,
    parameter int ROWS_LOG2 = 6,
    parameter int ADD_W     = 12,
    parameter int BASE_ADDR = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_datax,
    input  logic [WIDTH-1:0]   i_datay,
    output logic               o_ready,
    output logic [WIDTH+1:0]   o_data,
    output logic [ADD_W-1:0]   o_address,
    output logic               o_valid,
    output logic               o_bussy,
    output logic               o_done
);
    localparam int W     = 1 << COLS_LOG2;
    localparam int PIX_W = COLS_LOG2 + ROWS_LOG2;
    localparam logic [COLS_LOG2-1:0] COL_LAST = '1;
    localparam logic [ROWS_LOG2-1:0] ROW_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [COLS_LOG2-1:0]   col_q, col_d;
    logic [ROWS_LOG2-1:0]   row_q, row_d;
    logic                   accept, last_pix;
    logic [WIDTH-1:0]       px_prev_q;
    logic [WIDTH-1:0]       lbuf [W];
    logic [WIDTH-1:0]       py_above;
    logic [1:0]             vld_q;
    logic [WIDTH-1:0]       ax_q, bx_q, ay_q, by_q;
    logic [WIDTH-1:0]       ax_d, bx_d, ay_d, by_d;
    logic [PIX_W-1:0]       pix_q;
    logic [WIDTH:0]         dx, dy;
    logic [WIDTH+1:0]       sum;

    assign o_ready  = (state_q == RUN);
    assign o_bussy  = (state_q != IDLE);
    assign o_done   = (state_q == DONE);
    assign o_valid  = vld_q[1];
    assign accept   = i_valid & o_ready;
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign py_above = lbuf[col_q];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = RUN;
                mode_d  = i_mode;
                col_d   = '0;
                row_d   = '0;
            end
            RUN: if (accept) begin
                col_d = col_q + 1'b1;
                if (col_q == COL_LAST) row_d = row_q + 1'b1;
                if (last_pix) state_d = FLUSH;
            end
            FLUSH: if (!vld_q[0]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each difference is a - b; zero padding and the adjoint end-point rule
    // are folded in by forcing one operand to zero.
    always_comb begin
        ax_d = i_datax;
        bx_d = (col_q == '0) ? '0 : px_prev_q;
        ay_d = i_datay;
        by_d = (row_q == '0) ? '0 : py_above;
        if (!mode_q) begin
            if (col_q == COL_LAST) ax_d = '0;
            if (row_q == ROW_LAST) ay_d = '0;
        end
    end

    assign dx  = {ax_q[WIDTH-1], ax_q} - {bx_q[WIDTH-1], bx_q};
    assign dy  = {ay_q[WIDTH-1], ay_q} - {by_q[WIDTH-1], by_q};
    assign sum = {dx[WIDTH], dx} + {dy[WIDTH], dy};

    // Line buffer is read-before-write at the same column; never reset.
    always_ff @(posedge i_clk) begin
        if (accept) lbuf[col_q] <= i_datay;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            px_prev_q <= '0;
            vld_q     <= '0;
            ax_q      <= '0;
            bx_q      <= '0;
            ay_q      <= '0;
            by_q      <= '0;
            pix_q     <= '0;
            o_data    <= '0;
            o_address <= ADD_W'(BASE_ADDR);
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            col_q   <= col_d;
            row_q   <= row_d;
            vld_q   <= {vld_q[0], accept};
            if (accept) begin
                px_prev_q <= i_datax;
                ax_q      <= ax_d;
                bx_q      <= bx_d;
                ay_q      <= ay_d;
                by_q      <= by_d;
                pix_q     <= {row_q, col_q};
            end
            if (vld_q[0]) begin
                o_data    <= sum;
                o_address <= ADD_W'(BASE_ADDR) + ADD_W'(pix_q);
            end
        end
    end
endmodule

// File: tb/tb_div2d_stream.sv
// Scoreboard bench for div2d_stream on a 4x4, 8-bit frame: directed boundary
// frames, gap and reset cases, then random frames against a frame-level model.
module tb_div2d_stream;
    localparam int WIDTH = 8;
    localparam int CL    = 2;
    localparam int RL    = 2;
    localparam int ADD_W = 12;
    localparam int BASE  = 64;
    localparam int W     = 1 << CL;
    localparam int H     = 1 << RL;
    localparam int N     = W * H;

    logic               i_clk = 1'b0;
    logic               i_reset, i_start, i_mode, i_valid;
    logic [WIDTH-1:0]   i_datax, i_datay;
    logic               o_ready, o_valid, o_bussy, o_done;
    logic [WIDTH+1:0]   o_data;
    logic [ADD_W-1:0]   o_address;

    div2d_stream #(.WIDTH(WIDTH), .COLS_LOG2(CL), .ROWS_LOG2(RL),
                   .ADD_W(ADD_W), .BASE_ADDR(BASE)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode),
        .i_valid(i_valid), .i_datax(i_datax), .i_datay(i_datay),
        .o_ready(o_ready), .o_data(o_data), .o_address(o_address),
        .o_valid(o_valid), .o_bussy(o_bussy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { int d; int a; int t; } exp_t;
    exp_t sbq[$];
    int nchk = 0;
    int nerr = 0;
    int px_f [H][W];
    int py_f [H][W];
    int exp_f[H][W];

    task automatic chk(input string nm, input int act, input int req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Frame-level reference: divergence straight from the boundary rules.
    task automatic build_exp(input bit mode);
        int dx, dy;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (mode) begin
                    dx = px_f[r][c] - ((c > 0) ? px_f[r][c-1] : 0);
                    dy = py_f[r][c] - ((r > 0) ? py_f[r-1][c] : 0);
                end else begin
                    if (c == 0)          dx = px_f[r][0];
                    else if (c == W - 1) dx = -px_f[r][c-1];
                    else                 dx = px_f[r][c] - px_f[r][c-1];
                    if (r == 0)          dy = py_f[0][c];
                    else if (r == H - 1) dy = -py_f[r-1][c];
                    else                 dy = py_f[r][c] - py_f[r-1][c];
                end
                exp_f[r][c] = dx + dy;
            end
    endtask

    task automatic fill_const(input int x, input int y);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                px_f[r][c] = x;
                py_f[r][c] = y;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                px_f[r][c] = int'($urandom_range(0, 255)) - 128;
                py_f[r][c] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.d = exp_f[idx / W][idx % W];
        e.a = BASE + idx;
        e.t = cyc + 2;
        sbq.push_back(e);
    endtask

    // gap: 0 continuous, 1 alternate cycles, 2 random
    task automatic run_frame(input bit mode, input int gap, input bit poke);
        int idx = 0;
        int t = 0;
        int last_k = 0;
        bit seen = 1'b0;
        build_exp(mode);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_mode = mode;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_mode = ~mode;
        while (idx < N && t < 500) begin
            case (gap)
                0:       i_valid = 1'b1;
                1:       i_valid = (t % 2 == 0);
                default: i_valid = ($urandom_range(0, 2) != 0);
            endcase
            i_datax = 8'(px_f[idx / W][idx % W]);
            i_datay = 8'(py_f[idx / W][idx % W]);
            i_start = poke && (t == 3);
            @(negedge i_clk);
            chk("ready_in_run", int'(o_ready), 1);
            if (i_valid) begin
                push_exp(idx);
                last_k = cyc;
                idx++;
            end
            @(posedge i_clk); #1;
            t++;
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        if (idx < N) chk("frame_timeout", idx, N);
        @(negedge i_clk);
        chk("ready_in_flush", int'(o_ready), 0);
        chk("bussy_in_flush", int'(o_bussy), 1);
        for (int w = 0; w < 8 && !seen; w++) begin
            if (w > 0) @(negedge i_clk);
            if (o_done) begin
                seen = 1'b1;
                chk("done_cycle", cyc, last_k + 3);
            end
        end
        if (!seen) chk("done_seen", 0, 1);
        chk("sb_drained", sbq.size(), 0);
    endtask

    // Monitor: every o_valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_reset && o_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", int'(o_address), -1);
                end else begin
                    e = sbq.pop_front();
                    chk("data", int'($signed(o_data)), e.d);
                    chk("address", int'(o_address), e.a);
                    chk("latency", cyc, e.t);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_valid = 1'b0;
        i_datax = '0; i_datay = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_ready), 0);
        chk("rst_bussy", int'(o_bussy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_address", int'(o_address), BASE);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        // i_valid in IDLE must be ignored (monitor flags any output)
        i_valid = 1'b1; i_datax = 8'd5; i_datay = 8'd7;
        repeat (4) begin
            @(negedge i_clk);
            chk("idle_ready", int'(o_ready), 0);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;

        fill_const(1, 0); run_frame(1'b0, 0, 1'b0);
        fill_const(0, 1); run_frame(1'b0, 0, 1'b0);
        fill_const(1, 1); run_frame(1'b1, 0, 1'b0);
        fill_const(1, 0); run_frame(1'b0, 1, 1'b0);
        fill_const(0, 0);
        px_f[0][0] = -128; px_f[0][1] = 127; py_f[0][1] = 127;
        run_frame(1'b1, 0, 1'b0);

        // Reset after 7 accepted samples: in-flight results vanish, no o_done.
        fill_rand(); build_exp(1'b0);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_mode = 1'b0;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            i_valid = 1'b1;
            i_datax = 8'(px_f[k / W][k % W]);
            i_datay = 8'(py_f[k / W][k % W]);
            @(negedge i_clk);
            push_exp(k);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        sbq.delete();
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_data", int'(o_data), 0);
        chk("mid_rst_address", int'(o_address), BASE);
        chk("mid_rst_bussy", int'(o_bussy), 0);
        chk("mid_rst_ready", int'(o_ready), 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            chk("no_done_after_rst", int'(o_done), 0);
            chk("no_valid_after_rst", int'(o_valid), 0);
        end
        fill_rand(); run_frame(1'b0, 0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            fill_rand();
            run_frame(1'($urandom_range(0, 1)), 2, f == 2);
        end

        repeat (3) @(negedge i_clk);
        chk("final_sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
